// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (PC, instruction, dest address, write data, valid) with stall/flush.
// Define PIPE_REG_PERF_EN to add saturating stall and bubble performance counters.
module pipe_stage_reg #(
   parameter int          DATA_W           = 32,
   parameter int          ADDR_W           = 5,
   parameter logic [31:0] PC_RESET         = 32'h0000_3000,
   parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_i,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       instr_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
   output logic              valid_o,
   output logic [31:0]       pc_o,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] wa_o,
   output logic [DATA_W-1:0] wd_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       bubble_cnt_o
);

   // Control semantics: priority is reset > flush > stall > load. A flush inserts a
   // bubble even when stalled; a stall freezes every field including valid_o.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_o <= 1'b0;
         pc_o    <= PC_RESET;
         instr_o <= '0;
         wa_o    <= '0;
         wd_o    <= '0;
      end else if (flush) begin
         valid_o <= 1'b0;
         pc_o    <= KEEP_PC_ON_FLUSH ? pc_i : PC_RESET;
         instr_o <= '0;
         wa_o    <= '0;
         wd_o    <= '0;
      end else if (!stall) begin
         valid_o <= valid_i;
         pc_o    <= pc_i;
         // A bubble never carries a write-back address or an instruction downstream.
         instr_o <= valid_i ? instr_i : '0;
         wa_o    <= valid_i ? wa_i : '0;
         wd_o    <= wd_i;
      end
   end

`ifdef PIPE_REG_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] bubble_cnt_q;
   logic        stall_evt;
   logic        bubble_evt;

   assign stall_evt  = !flush && stall;
   assign bubble_evt = flush || (!stall && !valid_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign stall_cnt_o  = 32'h0;
   assign bubble_cnt_o = 32'h0;
`endif

endmodule
